// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge engine: raster pixels in, one gradient pixel out per input,
// valid/ready on both sides, two line buffers, zeroed borders and an optional threshold mode.
module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int SW = PIX_W + 2;
  localparam int MW = PIX_W + 4;
  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t           state_reg;
  logic [XW-1:0]    in_x_reg, out_x_reg, rd_addr;
  logic [YW-1:0]    in_y_reg, out_y_reg;
  logic             mode_reg;
  logic [PIX_W-1:0] thr_reg;
  logic [PIX_W-1:0] win_reg [3][3];
  logic [PIX_W-1:0] win_next [3][3];
  logic [PIX_W-1:0] col_new [3];
  logic [PIX_W-1:0] lb_rd [2];
  logic [PIX_W-1:0] lb_wd [2];
  logic             out_free, accept, load, border, in_x_last, in_y_last;
  logic [SW-1:0]    gx_p, gx_n, gy_p, gy_n, ax, ay;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] sat, pix_val, pix_next;

  function automatic logic [SW-1:0] sum121(input logic [PIX_W-1:0] a, b, c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a, b);
    return (a > b) ? a - b : b - a;
  endfunction

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = !reset && ((state_reg == FILL) || (state_reg == RUN && out_free));
  assign accept     = in_valid && in_ready;
  assign in_x_last  = (in_x_reg == X_LAST);
  assign in_y_last  = (in_y_reg == Y_LAST);
  assign frame_done = out_valid && out_ready && out_last;
  assign load       = (state_reg == RUN && accept) ||
                      (state_reg == FLUSH && out_free && !(out_valid && out_last));

  // Read one column ahead so the line-buffer data is already registered when the pixel arrives.
  always_comb begin
    rd_addr = in_x_reg;
    if (reset)
      rd_addr = '0;
    else if (accept)
      rd_addr = in_x_last ? '0 : in_x_reg + XW'(1);
  end

  // Line buffer 0 holds the previous line, line buffer 1 the one before it.
  assign lb_wd[0] = in_data;
  assign lb_wd[1] = lb_rd[0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    logic [PIX_W-1:0] mem [IMG_W];
    logic [PIX_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (accept)
        mem[in_x_reg] <= lb_wd[gi];
      rd_q <= mem[rd_addr];
    end
    assign lb_rd[gi] = rd_q;
  end

  assign col_new[0] = lb_rd[1];
  assign col_new[1] = lb_rd[0];
  assign col_new[2] = in_data;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign win_next[gi][0] = win_reg[gi][1];
    assign win_next[gi][1] = win_reg[gi][2];
    assign win_next[gi][2] = col_new[gi];
  end

  // Gradient of the window as it will stand after this accept.
  assign gx_p = sum121(win_next[0][2], win_next[1][2], win_next[2][2]);
  assign gx_n = sum121(win_next[0][0], win_next[1][0], win_next[2][0]);
  assign gy_p = sum121(win_next[2][0], win_next[2][1], win_next[2][2]);
  assign gy_n = sum121(win_next[0][0], win_next[0][1], win_next[0][2]);
  assign ax   = abs_diff(gx_p, gx_n);
  assign ay   = abs_diff(gy_p, gy_n);
  assign mag  = MW'(ax) + MW'(ay);
  assign sat  = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];

  assign pix_val  = mode_reg ? ((sat > thr_reg) ? PIX_MAX : '0) : sat;
  assign border   = (out_x_reg == '0) || (out_x_reg == X_LAST) ||
                    (out_y_reg == '0) || (out_y_reg == Y_LAST);
  assign pix_next = border ? '0 : pix_val;

  always_ff @(posedge clk) begin
    if (accept)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_reg[r][c] <= win_next[r][c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FILL;
      in_x_reg  <= '0;
      in_y_reg  <= '0;
      out_x_reg <= '0;
      out_y_reg <= '0;
      mode_reg  <= 1'b0;
      thr_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state_reg == FILL && in_x_reg == '0 && in_y_reg == '0) begin
        mode_reg <= mode;
        thr_reg  <= threshold;
      end

      if (accept) begin
        in_x_reg <= in_x_last ? '0 : in_x_reg + XW'(1);
        if (in_x_last)
          in_y_reg <= in_y_last ? '0 : in_y_reg + YW'(1);
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pix_next;
        out_last  <= (out_x_reg == X_LAST) && (out_y_reg == Y_LAST);
        out_x_reg <= (out_x_reg == X_LAST) ? '0 : out_x_reg + XW'(1);
        if (out_x_reg == X_LAST)
          out_y_reg <= (out_y_reg == Y_LAST) ? '0 : out_y_reg + YW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state_reg)
        FILL:    if (accept && in_x_reg == '0 && in_y_reg == YW'(1)) state_reg <= RUN;
        RUN:     if (accept && in_x_last && in_y_last) state_reg <= FLUSH;
        FLUSH:   if (frame_done) state_reg <= FILL;
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed frame-level bench for sobel_stream on an 8x8 image: table of frame configurations
// with hand-computed edge counts, plus a per-pixel reference Sobel and a mid-frame reset sequence.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset, mode, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [7:0] threshold, in_data, out_data;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .mode(mode), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done)
  );

  // kind: 0 = constant 100, 1 = step (cols 0-3 = 0, 4-7 = 255), 2 = ramp x*2, 3 = ramp x*4
  typedef struct {
    int         kind;
    logic       md;
    logic [7:0] thr;
    bit         rnd;
    int         exp_ones;
  } cfg_t;

  cfg_t tbl [11];

  function automatic int pix(input int kind, input int x, input int y);
    if (y < 0 || y >= H) return 0;
    case (kind)
      0:       return 100;
      1:       return (x < 4) ? 0 : 255;
      2:       return x * 2;
      default: return x * 4;
    endcase
  endfunction

  function automatic int golden(input int kind, input logic md, input int thr, input int x, input int y);
    int gx, gy, m;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
    gx = (pix(kind, x+1, y-1) + 2*pix(kind, x+1, y) + pix(kind, x+1, y+1))
       - (pix(kind, x-1, y-1) + 2*pix(kind, x-1, y) + pix(kind, x-1, y+1));
    gy = (pix(kind, x-1, y+1) + 2*pix(kind, x, y+1) + pix(kind, x+1, y+1))
       - (pix(kind, x-1, y-1) + 2*pix(kind, x, y-1) + pix(kind, x+1, y-1));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    if (md) m = (m > thr) ? 255 : 0;
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present one pixel and wait (bounded) for it to be accepted.
  task automatic send_pixel(input int kind, input int k, output bit ok);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_data = 8'(pix(kind, k % W, k / W));
    while (!acc && budget < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    ok = acc;
  endtask

  // Stream n table entries back to back, comparing every output beat.
  task automatic run_seq(input int first, input int n);
    int ones [4];
    int beats, done_cnt;
    bit drv_ok;
    beats = 0;
    done_cnt = 0;
    drv_ok = 1'b1;
    for (int i = 0; i < 4; i++) ones[i] = 0;
    fork
      begin : drv
        for (int f = 0; f < n && drv_ok; f++) begin
          mode = tbl[first+f].md;
          threshold = tbl[first+f].thr;
          for (int k = 0; k < N && drv_ok; k++) begin
            if (tbl[first+f].rnd)
              while ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
              end
            send_pixel(tbl[first+f].kind, k, drv_ok);
          end
        end
      end
      begin : col
        int cyc, f, p;
        cyc = 0;
        while (beats < n * N && cyc < 4000 * n) begin
          f = (beats / N < n) ? beats / N : n - 1;
          out_ready = tbl[first+f].rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
          @(negedge clk);
          if (frame_done) done_cnt++;
          if (out_valid && out_ready) begin
            p = beats % N;
            check($sformatf("cfg%0d_pix%0d_data", first+f, p), int'(out_data),
                  golden(tbl[first+f].kind, tbl[first+f].md, int'(tbl[first+f].thr), p % W, p / W));
            check($sformatf("cfg%0d_pix%0d_last", first+f, p), int'(out_last), (p == N - 1) ? 1 : 0);
            if (out_data == 8'd255) ones[f]++;
            beats++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    check($sformatf("seq%0d_input_accepted", first), int'(drv_ok), 1);
    check($sformatf("seq%0d_beats", first), beats, n * N);
    check($sformatf("seq%0d_frame_done", first), done_cnt, n);
    for (int f = 0; f < n; f++) begin
      check($sformatf("cfg%0d_ones", first+f), ones[f], tbl[first+f].exp_ones);
      $display("frame cfg=%0d kind=%0d mode=%0d thr=%0d rnd=%0d ones=%0d", first+f,
               tbl[first+f].kind, tbl[first+f].md, tbl[first+f].thr, tbl[first+f].rnd, ones[f]);
    end
  endtask

  initial begin
    bit ok;
    // Step: interior cols 3,4 saturate (1020) on rows 1-6 -> 12 ones.
    // Ramp x*2: interior mag 16; ramp x*4: interior mag 32; 6x6 interior = 36.
    tbl[0]  = '{kind: 0, md: 1'b0, thr: 8'd0,   rnd: 1'b0, exp_ones: 0};
    tbl[1]  = '{kind: 1, md: 1'b0, thr: 8'd0,   rnd: 1'b0, exp_ones: 12};
    tbl[2]  = '{kind: 2, md: 1'b1, thr: 8'd15,  rnd: 1'b0, exp_ones: 36};
    tbl[3]  = '{kind: 2, md: 1'b1, thr: 8'd16,  rnd: 1'b0, exp_ones: 0};
    tbl[4]  = '{kind: 3, md: 1'b1, thr: 8'd31,  rnd: 1'b0, exp_ones: 36};
    tbl[5]  = '{kind: 3, md: 1'b1, thr: 8'd32,  rnd: 1'b0, exp_ones: 0};
    tbl[6]  = '{kind: 1, md: 1'b0, thr: 8'd0,   rnd: 1'b1, exp_ones: 12};
    tbl[7]  = '{kind: 2, md: 1'b0, thr: 8'd15,  rnd: 1'b0, exp_ones: 0};
    tbl[8]  = '{kind: 2, md: 1'b1, thr: 8'd15,  rnd: 1'b0, exp_ones: 36};
    tbl[9]  = '{kind: 2, md: 1'b0, thr: 8'd15,  rnd: 1'b0, exp_ones: 0};
    tbl[10] = '{kind: 1, md: 1'b0, thr: 8'd0,   rnd: 1'b0, exp_ones: 12};

    reset = 1'b1; mode = 1'b0; threshold = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_frame_done", int'(frame_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("fill_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_seq(i, 1);
    run_seq(7, 3);

    // Abort a frame after 30 input pixels; nothing stale may survive the reset.
    out_ready = 1'b1; mode = 1'b0; threshold = 8'd0;
    ok = 1'b1;
    for (int k = 0; k < 30 && ok; k++) send_pixel(1, k, ok);
    check("abort_inputs_accepted", int'(ok), 1);
    @(negedge clk);
    check("pre_reset_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_out_valid", int'(out_valid), 0);
    check("post_reset_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    run_seq(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
